modular_square_iter_wrapper: RTL and testbench
==============================================

# modular_square_iter_wrapper

Parametrised I/O wrapper around the `modular_square_2_cycles` core that runs a programmed number of back-to-back squarings instead of free-running. Sits between the host/AXI shell and the core. It provides configurable input/output register depth, a start/ready handshake, a per-iteration output stream, a `done` pulse on the final iteration, and a synchronous abort.

## Interface

Parameters:
- `MOD_LEN`, default 1024: modulus width in bits.
- `WORD_LEN`, default 16: nonredundant coefficient width.
- `BIT_LEN`, default 17: core coefficient width; must be > `WORD_LEN`.
- `REDUNDANT_ELEMENTS`, default 1: zero-filled upper coefficients.
- `NONREDUNDANT_ELEMENTS`, default `MOD_LEN/WORD_LEN`.
- `NUM_ELEMENTS`, default `REDUNDANT_ELEMENTS+NONREDUNDANT_ELEMENTS`.
- `IN_STAGES`, default 3: input pipeline depth; must be ≥ 1.
- `OUT_STAGES`, default 3: output pipeline depth; must be ≥ 1. Stage 0 is the core output.
- `OUT_WORD_LEN`, default 32: per-coefficient field width in `sq_out`; must be ≥ `BIT_LEN`.
- `ITER_W`, default 64: iteration counter width.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a run; accepted only when `ready`=1.
- `iterations` in `ITER_W`: squarings to perform; sampled with an accepted `start`.
- `sq_in` in `MOD_LEN`: initial value; sampled with an accepted `start`.
- `abort` in 1: synchronous cancel of the current run.
- `ready` out 1: idle, can accept `start`.
- `sq_out` out `NUM_ELEMENTS*OUT_WORD_LEN`: coefficient j is zero-extended into `[j*OUT_WORD_LEN +: OUT_WORD_LEN]`.
- `valid` out 1: one pulse per completed squaring of the current run.
- `done` out 1: one-cycle pulse marking the final squaring or a zero-iteration run.

## Operation

- **Input split:** element j < `NONREDUNDANT_ELEMENTS` = `{0, sq_in[j*WORD_LEN +: WORD_LEN]}` at `BIT_LEN`. Redundant elements = 0.
- **FSM IDLE:**
  - `ready`=1.
  - `start` with `iterations`≠0: latch `iterations` into `remaining`, launch the start token and data into the input pipeline, go to RUN.
  - `start` with `iterations`=0: core is not started; `done` pulses next cycle; stay IDLE.
- **FSM RUN:**
  - `ready`=0.
  - The core receives start after `IN_STAGES` cycles.
  - Each `valid_stages[OUT_STAGES-1]` decrements `remaining`.
  - When `remaining`=1 and valid: `done`=1 in the same cycle as that `valid`, go to STOP.
- **FSM STOP:** one cycle. Asserts core reset (`core_reset = reset | stop | abort_q`), clears `remaining`, returns to IDLE.
- **Output gating:**
  - `valid` = `valid_stages[OUT_STAGES-1]` AND state==RUN.
  - In-flight valids after done or abort are masked.
  - `sq_out` is not gated; it is meaningful only with `valid`.
- **Abort:**
  - From any state, the next state is STOP, then IDLE; no `done`.
  - The input pipeline start tokens are cleared.
  - Abort in IDLE is harmless and costs one cycle of STOP with `ready`=0.
- **Busy start:** `start` while `ready`=0 is ignored, with no side effects.
- **Simultaneity:**
  - `abort` beats final valid: no `done`, and `valid` is masked that cycle.
  - `abort` beats `start`.
  - `reset` beats everything.
- **Counter width:** `ITER_W` bits; no wrap, since decrement stops at 1. Max `2^ITER_W-1` iterations.

## Timing

- **Reset values:** `ready`=1 (after the cycle `reset` deasserts), `valid`=0, `done`=0, state IDLE, `remaining`=0. All pipeline start/valid bits and data stages = 0.
- **Start to core:** `start` accepted at edge k; the core sees `start` at edge k+`IN_STAGES`.
- **Core to output:** a core valid at cycle c appears on `valid`/`sq_out` at c+`OUT_STAGES`-1.
- **Back-to-back runs:** `done` at cycle d, STOP at d+1, `ready`=1 at d+2. Earliest new `start` is accepted at d+2.
- **Zero-iteration run:** `start` at k, `done` at k+1, `ready` stays 1.

## Test plan

- **Packing:** `sq_in` = 0x0001_FFFF (upper bits 0), `iterations`=1 → core input element0=0x0FFFF, element1=0x00001, redundant element=0. Exactly one `valid`, coincident with `done`; `sq_out` equals the core model result, zero-extended to 32 bits per field.
- **Multi-iteration:** `iterations`=5 → exactly 5 `valid` pulses, `done` only with the 5th, `ready` high 2 cycles later. No `valid` afterwards for 50 cycles.
- **Zero iterations:** `iterations`=0 → `done` one cycle after `start`, zero `valid`, core `start` never asserted, `ready` never drops.
- **Abort:** `iterations`=10, `abort` after the 3rd `valid` → no `done`, no further `valid`, `ready`=1 two cycles after `abort`. A following run with `iterations`=2 completes normally.
- **Busy start:** `start` with `iterations`=7 pulsed during a 4-iteration run → ignored; exactly 4 valids and one `done`.
- **Reset mid-run:** `reset` asserted for 1 cycle mid-run → all outputs at reset values the next cycle, no `done`. Repeat with `IN_STAGES`=1, `OUT_STAGES`=1 and with `IN_STAGES`=5, `OUT_STAGES`=4, checking that latency shifts exactly by the stage counts.

Source files
------------

// File: rtl/modular_square_iter_wrapper.sv
// Iterated modular squaring: wraps modular_square_2_cycles with input/output register
// stages, a start/ready handshake, a programmed iteration count, done pulse and abort.

module modular_square_2_cycles #(
  parameter int MOD_LEN = 1024,
  parameter int WORD_LEN = 16,
  parameter int BIT_LEN = 17,
  parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
  parameter int NUM_ELEMENTS = NONREDUNDANT_ELEMENTS + 1,
  parameter logic [MOD_LEN-1:0] MODULUS = '1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]  sq_in,
  output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]  sq_out,
  output logic                                  valid
);
  localparam int VAL_W = NUM_ELEMENTS * WORD_LEN + BIT_LEN;

  logic [VAL_W-1:0]     in_sum;
  logic [VAL_W-1:0]     in_red;
  logic [MOD_LEN-1:0]   cur;
  logic [2*MOD_LEN-1:0] prod;
  logic [2*MOD_LEN-1:0] prod_red;
  logic                 running;
  logic                 phase;

  // Redundant coefficients overlap by BIT_LEN-WORD_LEN bits, so fold them by weighted sum.
  always_comb begin
    in_sum = '0;
    for (int j = 0; j < NUM_ELEMENTS; j++)
      in_sum = in_sum + (VAL_W'(sq_in[j]) << (j * WORD_LEN));
  end

  assign in_red   = in_sum % VAL_W'(MODULUS);
  assign prod     = {{MOD_LEN{1'b0}}, cur} * {{MOD_LEN{1'b0}}, cur};
  assign prod_red = prod % {{MOD_LEN{1'b0}}, MODULUS};

  always_comb begin
    sq_out = '0;
    for (int j = 0; j < NONREDUNDANT_ELEMENTS; j++)
      sq_out[j] = BIT_LEN'(cur[j*WORD_LEN +: WORD_LEN]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= '0;
      running <= 1'b0;
      phase   <= 1'b0;
      valid   <= 1'b0;
    end else if (start) begin
      cur     <= MOD_LEN'(in_red);
      running <= 1'b1;
      phase   <= 1'b0;
      valid   <= 1'b0;
    end else if (running) begin
      phase <= ~phase;
      valid <= phase;
      if (phase)
        cur <= MOD_LEN'(prod_red);
    end
  end
endmodule

module modular_square_iter_wrapper #(
  parameter int MOD_LEN = 1024,
  parameter int WORD_LEN = 16,
  parameter int BIT_LEN = 17,
  parameter int REDUNDANT_ELEMENTS = 1,
  parameter int NONREDUNDANT_ELEMENTS = MOD_LEN / WORD_LEN,
  parameter int NUM_ELEMENTS = REDUNDANT_ELEMENTS + NONREDUNDANT_ELEMENTS,
  parameter int IN_STAGES = 3,
  parameter int OUT_STAGES = 3,
  parameter int OUT_WORD_LEN = 32,
  parameter int ITER_W = 64,
  parameter logic [MOD_LEN-1:0] MODULUS = '1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [ITER_W-1:0]                  iterations,
  input  logic [MOD_LEN-1:0]                 sq_in,
  input  logic                               abort,
  output logic                               ready,
  output logic [NUM_ELEMENTS*OUT_WORD_LEN-1:0] sq_out,
  output logic                               valid,
  output logic                               done
);
  // state  | meaning
  // S_IDLE | ready, waiting for start
  // S_RUN  | core squaring, counting output valids
  // S_STOP | one cycle holding the core in reset, then back to idle
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  typedef logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] coeffs_t;

  state_t            state;
  logic [ITER_W-1:0] remaining;
  logic              done_zero;
  logic              abort_q;
  logic              launch;
  logic              final_valid;
  logic              core_reset;
  logic              core_start;
  logic              core_valid;
  logic              last_valid;
  coeffs_t           sq_split;
  coeffs_t           core_in;
  coeffs_t           core_out;
  coeffs_t           last_data;
  logic [IN_STAGES-1:0] in_start;
  coeffs_t           in_data [IN_STAGES];

  always_comb begin
    sq_split = '0;
    for (int j = 0; j < NONREDUNDANT_ELEMENTS; j++)
      sq_split[j] = BIT_LEN'(sq_in[j*WORD_LEN +: WORD_LEN]);
  end

  assign ready       = (state == S_IDLE);
  assign launch      = start && (state == S_IDLE) && !abort && (iterations != '0);
  assign valid       = last_valid && (state == S_RUN) && !abort;
  assign final_valid = valid && (remaining == ITER_W'(1));
  assign done        = final_valid || done_zero;
  assign core_reset  = reset || (state == S_STOP) || abort_q;
  assign core_start  = in_start[IN_STAGES-1];
  assign core_in     = in_data[IN_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      in_start <= '0;
      for (int i = 0; i < IN_STAGES; i++)
        in_data[i] <= '0;
    end else begin
      in_start[0] <= launch;
      in_data[0]  <= sq_split;
      for (int i = 1; i < IN_STAGES; i++) begin
        in_start[i] <= in_start[i-1];
        in_data[i]  <= in_data[i-1];
      end
      if (abort)
        in_start <= '0;
    end
  end

  modular_square_2_cycles #(
    .MOD_LEN(MOD_LEN), .WORD_LEN(WORD_LEN), .BIT_LEN(BIT_LEN),
    .NONREDUNDANT_ELEMENTS(NONREDUNDANT_ELEMENTS), .NUM_ELEMENTS(NUM_ELEMENTS),
    .MODULUS(MODULUS)
  ) u_core (
    .clk(clk), .reset(core_reset), .start(core_start), .sq_in(core_in),
    .sq_out(core_out), .valid(core_valid)
  );

  // Stage 0 is the core's own output register; extra stages flush on core reset.
  if (OUT_STAGES == 1) begin : g_out_direct
    assign last_valid = core_valid;
    assign last_data  = core_out;
  end else begin : g_out_pipe
    logic [OUT_STAGES-2:0] pipe_valid;
    coeffs_t               pipe_data [OUT_STAGES-1];

    always_ff @(posedge clk) begin
      if (core_reset) begin
        pipe_valid <= '0;
      end else begin
        pipe_valid[0] <= core_valid;
        for (int i = 1; i < OUT_STAGES-1; i++)
          pipe_valid[i] <= pipe_valid[i-1];
      end
      if (reset) begin
        for (int i = 0; i < OUT_STAGES-1; i++)
          pipe_data[i] <= '0;
      end else begin
        pipe_data[0] <= core_out;
        for (int i = 1; i < OUT_STAGES-1; i++)
          pipe_data[i] <= pipe_data[i-1];
      end
    end

    assign last_valid = pipe_valid[OUT_STAGES-2];
    assign last_data  = pipe_data[OUT_STAGES-2];
  end

  always_comb begin
    sq_out = '0;
    for (int j = 0; j < NUM_ELEMENTS; j++)
      sq_out[j*OUT_WORD_LEN +: OUT_WORD_LEN] = OUT_WORD_LEN'(last_data[j]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      done_zero <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      abort_q   <= abort;
      done_zero <= 1'b0;
      if (abort) begin
        state     <= S_STOP;
        remaining <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (iterations != '0) begin
                remaining <= iterations;
                state     <= S_RUN;
              end else begin
                done_zero <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (valid) begin
              remaining <= remaining - ITER_W'(1);
              if (final_valid)
                state <= S_STOP;
            end
          end
          default: begin
            remaining <= '0;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_modular_square_iter_wrapper.sv
// Directed bench for modular_square_iter_wrapper with a 32-bit modulus (2^32-5) and
// three stage configurations: (3,3) main, (1,1) and (5,4) for latency and reset checks.

module tb_modular_square_iter_wrapper;
  localparam logic [31:0] M = 32'hFFFFFFFB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] iterations = '0;
  logic [31:0] sq_in = '0;

  logic        ready, valid, done;
  logic [95:0] sq_out;
  logic        ready_a, valid_a, done_a;
  logic [95:0] sq_out_a;
  logic        ready_b, valid_b, done_b;
  logic [95:0] sq_out_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  modular_square_iter_wrapper #(
    .MOD_LEN(32), .WORD_LEN(16), .BIT_LEN(17), .IN_STAGES(3), .OUT_STAGES(3),
    .OUT_WORD_LEN(32), .ITER_W(16), .MODULUS(M)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .iterations(iterations), .sq_in(sq_in),
    .abort(abort), .ready(ready), .sq_out(sq_out), .valid(valid), .done(done)
  );

  modular_square_iter_wrapper #(
    .MOD_LEN(32), .WORD_LEN(16), .BIT_LEN(17), .IN_STAGES(1), .OUT_STAGES(1),
    .OUT_WORD_LEN(32), .ITER_W(16), .MODULUS(M)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .iterations(iterations), .sq_in(sq_in),
    .abort(abort), .ready(ready_a), .sq_out(sq_out_a), .valid(valid_a), .done(done_a)
  );

  modular_square_iter_wrapper #(
    .MOD_LEN(32), .WORD_LEN(16), .BIT_LEN(17), .IN_STAGES(5), .OUT_STAGES(4),
    .OUT_WORD_LEN(32), .ITER_W(16), .MODULUS(M)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .iterations(iterations), .sq_in(sq_in),
    .abort(abort), .ready(ready_b), .sq_out(sq_out_b), .valid(valid_b), .done(done_b)
  );

  function automatic logic [31:0] sqm(input logic [31:0] a);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, a};
    return 32'(p % {32'h0, M});
  endfunction

  function automatic logic [95:0] fields(input logic [31:0] v);
    return {32'h0, 16'h0, v[31:16], 16'h0, v[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (sq_out !== 96'h0) begin errors++; $display("FAIL reset_sq_out: got %h expected 0", sq_out); end
  endtask

  task automatic test_latency();
    int lat [3];
    int nv [3];
    int nd [3];
    int bad;
    lat = '{-1, -1, -1};
    nv = '{0, 0, 0};
    nd = '{0, 0, 0};
    iterations = 16'd3; sq_in = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      tick();
      if (valid)   begin nv[0]++; if (lat[0] < 0) lat[0] = n; end
      if (valid_a) begin nv[1]++; if (lat[1] < 0) lat[1] = n; end
      if (valid_b) begin nv[2]++; if (lat[2] < 0) lat[2] = n; end
      if (done) nd[0]++;
      if (done_a) nd[1]++;
      if (done_b) nd[2]++;
    end
    checks++; if (lat[0] != 7) begin errors++; $display("FAIL latency_3_3: got %0d expected 7", lat[0]); end
    checks++; if (lat[1] != 3) begin errors++; $display("FAIL latency_1_1: got %0d expected 3", lat[1]); end
    checks++; if (lat[2] != 10) begin errors++; $display("FAIL latency_5_4: got %0d expected 10", lat[2]); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (nv[i] != 3) begin errors++; $display("FAIL latency_valids[%0d]: got %0d expected 3", i, nv[i]); end
      checks++; if (nd[i] != 1) begin errors++; $display("FAIL latency_dones[%0d]: got %0d expected 1", i, nd[i]); end
    end

    // Reset mid-run on all three configurations.
    iterations = 16'd10; sq_in = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({ready, ready_a, ready_b} !== 3'b111) begin errors++; $display("FAIL midreset_ready: got %b expected 111", {ready, ready_a, ready_b}); end
    checks++; if ({valid, valid_a, valid_b} !== 3'b000) begin errors++; $display("FAIL midreset_valid: got %b expected 000", {valid, valid_a, valid_b}); end
    checks++; if ({done, done_a, done_b} !== 3'b000) begin errors++; $display("FAIL midreset_done: got %b expected 000", {done, done_a, done_b}); end
    checks++; if ({sq_out, sq_out_a, sq_out_b} !== 288'h0) begin errors++; $display("FAIL midreset_sq_out: got %h %h %h expected 0", sq_out, sq_out_a, sq_out_b); end
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (valid || valid_a || valid_b || done || done_a || done_b) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_packing();
    logic [50:0] exp_in;
    int nv, nd, ncs, nsep;
    exp_in = {17'h0, 17'h00001, 17'h0FFFF};
    nv = 0; nd = 0; ncs = 0; nsep = 0;
    iterations = 16'd1; sq_in = 32'h0001_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (dut.core_start) begin
        ncs++;
        checks++; if (dut.core_in !== exp_in) begin errors++; $display("FAIL packing_core_in: got %h expected %h", dut.core_in, exp_in); end
      end
      if (valid) begin
        nv++;
        checks++; if (sq_out !== fields(32'hFFFC0010)) begin errors++; $display("FAIL packing_sq_out: got %h expected %h", sq_out, fields(32'hFFFC0010)); end
      end
      if (done) nd++;
      if (valid != done) nsep++;
    end
    checks++; if (ncs != 1) begin errors++; $display("FAIL packing_core_start: got %0d expected 1", ncs); end
    checks++; if (nv != 1) begin errors++; $display("FAIL packing_valids: got %0d expected 1", nv); end
    checks++; if (nd != 1) begin errors++; $display("FAIL packing_dones: got %0d expected 1", nd); end
    checks++; if (nsep != 0) begin errors++; $display("FAIL packing_done_with_valid: got %0d split cycles expected 0", nsep); end
  endtask

  task automatic test_multi();
    logic [31:0] exp;
    int nv, nd, td, bad;
    exp = 32'd3; nv = 0; nd = 0; td = -1; bad = 0;
    iterations = 16'd5; sq_in = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (valid) begin
        nv++;
        exp = sqm(exp);
        checks++; if (sq_out !== fields(exp)) begin errors++; $display("FAIL multi_sq_out[%0d]: got %h expected %h", nv, sq_out, fields(exp)); end
      end
      if (done) begin
        nd++;
        td = n;
        checks++; if (!(valid && nv == 5)) begin errors++; $display("FAIL multi_done_position: got valid=%b count=%0d expected 1 and 5", valid, nv); end
      end
      if (td >= 0 && n == td + 1) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL multi_stop_ready: got %b expected 0", ready); end
      end
      if (td >= 0 && n == td + 2) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL multi_ready_after: got %b expected 1", ready); end
      end
    end
    checks++; if (nv != 5) begin errors++; $display("FAIL multi_valids: got %0d expected 5", nv); end
    checks++; if (td != 15) begin errors++; $display("FAIL multi_done_cycle: got %0d expected 15", td); end
    for (int n = 0; n < 50; n++) begin
      tick();
      if (valid || done) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL multi_quiet: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_zero();
    int nd, nv, ncs, drop;
    nd = 0; nv = 0; ncs = 0; drop = 0;
    iterations = 16'd0; sq_in = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", ready); end
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done) nd++;
      if (valid) nv++;
      if (dut.core_start) ncs++;
      if (!ready) drop++;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL zero_extra_done: got %0d expected 0", nd); end
    checks++; if (nv != 0) begin errors++; $display("FAIL zero_valids: got %0d expected 0", nv); end
    checks++; if (ncs != 0) begin errors++; $display("FAIL zero_core_start: got %0d expected 0", ncs); end
    checks++; if (drop != 0) begin errors++; $display("FAIL zero_ready_drop: got %0d expected 0", drop); end
  endtask

  task automatic test_abort();
    logic [31:0] exp;
    int nv, nd, bad, guard;
    nv = 0; nd = 0; bad = 0; guard = 0;
    iterations = 16'd10; sq_in = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    while (nv < 3 && guard < 40) begin
      tick();
      guard++;
      if (valid) nv++;
      if (done) nd++;
    end
    checks++; if (nv != 3) begin errors++; $display("FAIL abort_reach_third: got %0d valids expected 3", nv); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_stop_ready: got %b expected 0", ready); end
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready_after: got %b expected 1", ready); end
    for (int n = 0; n < 40; n++) begin
      tick();
      if (valid) bad++;
      if (done) nd++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_extra_valid: got %0d expected 0", bad); end
    checks++; if (nd != 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", nd); end

    exp = 32'd5; nv = 0; nd = 0;
    iterations = 16'd2; sq_in = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (valid) begin
        nv++;
        exp = sqm(exp);
        checks++; if (sq_out !== fields(exp)) begin errors++; $display("FAIL abort_rerun_sq_out[%0d]: got %h expected %h", nv, sq_out, fields(exp)); end
      end
      if (done) nd++;
    end
    checks++; if (nv != 2) begin errors++; $display("FAIL abort_rerun_valids: got %0d expected 2", nv); end
    checks++; if (nd != 1) begin errors++; $display("FAIL abort_rerun_dones: got %0d expected 1", nd); end
  endtask

  task automatic test_abort_final();
    int bad;
    bad = 0;
    iterations = 16'd1; sq_in = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL abort_final_pre_valid: got %b expected 1", valid); end
    abort = 1'b1;
    #1;
    checks++; if ({valid, done} !== 2'b00) begin errors++; $display("FAIL abort_final_mask: got valid,done=%b expected 00", {valid, done}); end
    tick();
    abort = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_final_stop: got %b expected 0", ready); end
    for (int n = 0; n < 20; n++) begin
      tick();
      if (valid || done || !ready) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_final_quiet: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_abort_start();
    int bad;
    bad = 0;
    iterations = 16'd3; sq_in = 32'd3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_start_stop: got %b expected 0", ready); end
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_start_ready: got %b expected 1", ready); end
    for (int n = 0; n < 20; n++) begin
      tick();
      if (valid || done) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_start_quiet: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_busy_start();
    logic [31:0] exp;
    int nv, nd;
    exp = 32'd2; nv = 0; nd = 0;
    iterations = 16'd4; sq_in = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 3) begin start = 1'b1; iterations = 16'd7; sq_in = 32'd9; end
      if (n == 4) start = 1'b0;
      if (valid) begin
        nv++;
        exp = sqm(exp);
        checks++; if (sq_out !== fields(exp)) begin errors++; $display("FAIL busy_sq_out[%0d]: got %h expected %h", nv, sq_out, fields(exp)); end
      end
      if (done) nd++;
    end
    checks++; if (nv != 4) begin errors++; $display("FAIL busy_valids: got %0d expected 4", nv); end
    checks++; if (nd != 1) begin errors++; $display("FAIL busy_dones: got %0d expected 1", nd); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL busy_ready_end: got %b expected 1", ready); end
  endtask

  task automatic test_back_to_back();
    int td, nv, nd, lat, guard;
    td = -1; guard = 0; nv = 0; nd = 0; lat = -1;
    iterations = 16'd2; sq_in = 32'h10; start = 1'b1;
    tick();
    start = 1'b0;
    while (td < 0 && guard < 30) begin
      tick();
      guard++;
      if (done) td = guard;
    end
    checks++; if (td != 9) begin errors++; $display("FAIL b2b_first_done: got %0d expected 9", td); end
    tick();
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", ready); end
    iterations = 16'd1; sq_in = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: got %b expected 0", ready); end
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (valid) begin
        nv++;
        if (lat < 0) lat = n;
        checks++; if (sq_out !== fields(32'd9)) begin errors++; $display("FAIL b2b_sq_out: got %h expected %h", sq_out, fields(32'd9)); end
      end
      if (done) nd++;
    end
    checks++; if (lat != 7) begin errors++; $display("FAIL b2b_latency: got %0d expected 7", lat); end
    checks++; if (nv != 1 || nd != 1) begin errors++; $display("FAIL b2b_counts: got valids=%0d dones=%0d expected 1 1", nv, nd); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_packing();
    test_multi();
    test_zero();
    test_abort();
    test_abort_final();
    test_abort_start();
    test_busy_start();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
